// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus with a single parked split transaction.
// All outputs registered; a released or split bus always spends one IDLE cycle before the next grant.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic [SEL_WIDTH-1:0]   msel,
  output logic                   bus_busy,
  input  logic                   ssplit,
  input  logic                   split_done,
  output logic                   split_err
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  state_t                 state, state_nxt;
  logic [SEL_WIDTH-1:0]   owner, owner_nxt;
  logic [SEL_WIDTH-1:0]   rr, rr_nxt;
  logic [SEL_WIDTH-1:0]   split_owner, split_owner_nxt;
  logic                   split_pending, split_pending_nxt;
  logic                   split_ready, split_ready_nxt;
  logic [NUM_MASTERS-1:0] owner_oh, split_oh, eligible;
  logic [NUM_MASTERS-1:0] bgrant_nxt, msplit_nxt;
  logic                   bus_busy_nxt, split_err_nxt;
  logic                   pick_vld;
  logic [SEL_WIDTH-1:0]   pick, pick_rr;
  logic                   owner_req, split_req;

  assign owner_oh  = ONE << owner;
  assign split_oh  = ONE << split_owner;
  assign owner_req = |(breq & owner_oh);
  assign split_req = |(breq & split_oh);
  assign eligible  = breq & ~(split_pending ? split_oh : '0);
  assign msel      = owner;

  // rr holds the index where the next search starts (one past the last normal grant),
  // so a reset value of 0 gives master 0 first priority.
  always_comb begin : rr_search
    int c;
    int n;
    pick_vld = 1'b0;
    pick     = '0;
    pick_rr  = '0;
    c        = 0;
    n        = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      c = int'(rr) + i;
      if (c >= NUM_MASTERS) c = c - NUM_MASTERS;
      n = (c == NUM_MASTERS - 1) ? 0 : c + 1;
      if (!pick_vld && (|(eligible & (ONE << c)))) begin
        pick_vld = 1'b1;
        pick     = SEL_WIDTH'(c);
        pick_rr  = SEL_WIDTH'(n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      owner         <= '0;
      rr            <= '0;
      split_owner   <= '0;
      split_pending <= 1'b0;
      split_ready   <= 1'b0;
      bgrant        <= '0;
      msplit        <= '0;
      bus_busy      <= 1'b0;
      split_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      rr            <= rr_nxt;
      split_owner   <= split_owner_nxt;
      split_pending <= split_pending_nxt;
      split_ready   <= split_ready_nxt;
      bgrant        <= bgrant_nxt;
      msplit        <= msplit_nxt;
      bus_busy      <= bus_busy_nxt;
      split_err     <= split_err_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    owner_nxt         = owner;
    rr_nxt            = rr;
    split_owner_nxt   = split_owner;
    split_pending_nxt = split_pending;
    split_ready_nxt   = split_ready;

    if (split_done && split_pending) split_ready_nxt = 1'b1;
    // A parked master that gives up its request becomes an ordinary requester again.
    if (split_pending && !split_req) begin
      split_pending_nxt = 1'b0;
      split_ready_nxt   = 1'b0;
    end

    case (state)
      IDLE: begin
        if (split_pending && split_ready && split_req) begin
          state_nxt         = OWNED;
          owner_nxt         = split_owner;
          split_pending_nxt = 1'b0;
          split_ready_nxt   = 1'b0;
        end else if (pick_vld) begin
          state_nxt = OWNED;
          owner_nxt = pick;
          rr_nxt    = pick_rr;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (ssplit && !split_pending) begin
          state_nxt         = IDLE;
          split_owner_nxt   = owner;
          split_pending_nxt = 1'b1;
          split_ready_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bgrant_nxt    = (state_nxt == OWNED) ? (ONE << owner_nxt) : '0;
    msplit_nxt    = split_pending_nxt ? (ONE << split_owner_nxt) : '0;
    bus_busy_nxt  = (state_nxt == OWNED);
    split_err_nxt = (state == OWNED) && ssplit && split_pending;
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboarded bench: directed scenarios then random traffic, checked against an integer-level model.
module tb_serial_bus_arbiter;

  localparam int N  = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  breq;
  logic [N-1:0]  bgrant;
  logic [N-1:0]  msplit;
  logic [SW-1:0] msel;
  logic          bus_busy;
  logic          ssplit;
  logic          split_done;
  logic          split_err;

  always #5 clk = ~clk;

  serial_bus_arbiter #(.NUM_MASTERS(N), .SEL_WIDTH(SW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .breq       (breq),
    .bgrant     (bgrant),
    .msplit     (msplit),
    .msel       (msel),
    .bus_busy   (bus_busy),
    .ssplit     (ssplit),
    .split_done (split_done),
    .split_err  (split_err)
  );

  typedef struct packed {
    logic [N-1:0]  bgrant;
    logic [N-1:0]  msplit;
    logic [SW-1:0] msel;
    logic          bus_busy;
    logic          split_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: who owns the bus (if anyone), where the next search starts,
  // and the parked master with its "slave is ready" flag.
  bit m_owned;
  int m_owner;
  int m_start;
  bit m_pend;
  int m_park;
  bit m_ready;

  task automatic model_step(input logic [N-1:0] b, input logic ss, input logic sd,
                            input logic rn, output exp_t e);
    bit o_owned, o_pend, o_ready, err;
    int o_owner, idx;
    bit found;
    err = 1'b0;
    if (!rn) begin
      m_owned = 0; m_owner = 0; m_start = 0; m_pend = 0; m_park = 0; m_ready = 0;
    end else begin
      o_owned = m_owned; o_owner = m_owner; o_pend = m_pend; o_ready = m_ready;
      err = o_owned && ss && o_pend;
      if (sd && o_pend) m_ready = 1;
      if (o_pend && !b[m_park]) begin
        m_pend = 0; m_ready = 0;
      end
      if (!o_owned) begin
        if (o_pend && o_ready && b[m_park]) begin
          m_owned = 1; m_owner = m_park; m_pend = 0; m_ready = 0;
        end else begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            idx = (m_start + k) % N;
            if (!found && b[idx] && !(o_pend && idx == m_park)) begin
              found = 1; m_owned = 1; m_owner = idx; m_start = (idx + 1) % N;
            end
          end
        end
      end else if (!b[o_owner]) begin
        m_owned = 0;
      end else if (ss && !o_pend) begin
        m_owned = 0; m_pend = 1; m_park = o_owner; m_ready = 0;
      end
    end
    e.bgrant    = m_owned ? (N'(1) << m_owner) : '0;
    e.msplit    = m_pend ? (N'(1) << m_park) : '0;
    e.msel      = SW'(m_owner);
    e.bus_busy  = m_owned;
    e.split_err = err;
  endtask

  // One stimulus cycle; word = {rstn, split_done, ssplit, breq}.
  task automatic drive(input logic [N+2:0] w);
    exp_t e;
    @(negedge clk);
    rstn       = w[N+2];
    split_done = w[N+1];
    ssplit     = w[N];
    breq       = w[N-1:0];
    model_step(breq, ssplit, split_done, rstn, e);
    exp_q.push_back(e);
  endtask

  task automatic rep(input logic [N+2:0] w, input int n);
    for (int i = 0; i < n; i++) drive(w);
  endtask

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bgrant",    8'(bgrant),    8'(e.bgrant));
        chk("msplit",    8'(msplit),    8'(e.msplit));
        chk("msel",      8'(msel),      8'(e.msel));
        chk("bus_busy",  8'(bus_busy),  8'(e.bus_busy));
        chk("split_err", 8'(split_err), 8'(e.split_err));
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] rb;
    logic         rn, ss, sd;
    rstn = 1'b0; breq = '0; ssplit = 1'b0; split_done = 1'b0;
    m_owned = 0; m_owner = 0; m_start = 0; m_pend = 0; m_park = 0; m_ready = 0;

    rep(5'b0_0_0_00, 2);
    // single master
    rep(5'b1_0_0_01, 5);
    rep(5'b1_0_0_00, 2);
    // round robin with both masters requesting
    rep(5'b1_0_0_11, 4); rep(5'b1_0_0_10, 1);
    rep(5'b1_0_0_11, 3); rep(5'b1_0_0_01, 1);
    rep(5'b1_0_0_11, 3); rep(5'b1_0_0_10, 1);
    rep(5'b1_0_0_11, 3); rep(5'b1_0_0_01, 1);
    rep(5'b1_0_0_00, 2);
    // split, late split_done, resume ahead of M1
    rep(5'b1_0_0_01, 2); rep(5'b1_0_1_11, 1);
    rep(5'b1_0_0_11, 2); rep(5'b1_1_0_11, 1);
    rep(5'b1_0_0_11, 2); rep(5'b1_0_0_01, 1);
    rep(5'b1_0_0_11, 3); rep(5'b1_0_0_10, 3);
    rep(5'b1_0_0_00, 2);
    // double split then cancel
    rep(5'b1_0_0_01, 2); rep(5'b1_0_1_11, 1);
    rep(5'b1_0_0_11, 2); rep(5'b1_0_1_11, 1);
    rep(5'b1_0_0_11, 1); rep(5'b1_0_0_10, 2);
    rep(5'b1_1_0_10, 1); rep(5'b1_0_0_10, 2);
    rep(5'b1_0_0_00, 2);
    // reset mid-transaction
    rep(5'b1_0_0_01, 2); rep(5'b1_0_1_11, 1);
    rep(5'b1_0_0_11, 2); rep(5'b0_0_0_11, 1);
    rep(5'b1_0_0_11, 3); rep(5'b1_0_0_00, 2);

    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) rb[i] = ~rb[i];
      ss = ($urandom_range(5) == 0);
      sd = ($urandom_range(7) == 0);
      rn = ($urandom_range(199) != 0);
      drive({rn, sd, ss, rb});
    end
    rep(5'b1_0_0_00, 3);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
